data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_pkg.sv | 6 +
 rtl/dmem_array.sv | 18 +
 rtl/data_mem_responder.sv | 89 ++++++++
 tb/tb_data_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared widths and FSM state encoding for the data memory responder.
package data_mem_pkg;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 16;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32-bit word store, one synchronous write port, one combinational read port.
module dmem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with WAIT-cycle latency.
// Define DMEM_ERR_EN to flag misaligned or out-of-range accesses via rsp_err.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH);
    state_t            state;
    logic [3:0]        cnt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rd_data;
    logic [IDX_W-1:0]  idx;
    logic              err;
    logic              fire;
    logic              we;
`ifdef DMEM_ERR_EN
    assign err = (addr_q[1:0] != 2'b00) || (32'(addr_q[ADDR_W-1:2]) >= DEPTH);
`else
    logic unused_addr;
    assign unused_addr = ^addr_q;
    assign err = 1'b0;
`endif
    assign idx       = addr_q[IDX_W+1:2];
    assign fire      = (state == data_mem_pkg::WAIT) && (cnt == 4'd0);
    assign we        = fire && write_q && !err;
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (idx),
        .wdata (wdata_q),
        .raddr (idx),
        .rdata (rd_data)
    );
    // The count starts at WAIT so that RESP is entered WAIT+1 edges after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state   <= data_mem_pkg::WAIT;
                    cnt     <= 4'(WAIT);
                    write_q <= req_write;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                end
                data_mem_pkg::WAIT: if (fire) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= (write_q || err) ? '0 : rd_data;
                    rsp_err   <= err;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (WAIT=2 main instance, WAIT=0 throughput instance).
module tb_data_mem_responder;
    localparam int WAIT_P = 2;
    typedef struct {logic [31:0] rdata; logic err;} exp_t;
    logic clk = 0;
    logic rst_n = 0;
    logic req_valid = 0, req_write = 0, rsp_ready = 1;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic v0 = 0, rdy0, rv0, err0, busy0;
    logic [31:0] rdata0;
    exp_t exp_q[$];
    logic [31:0] ref_mem [int];
    int n_checks = 0, n_errors = 0;
    int cyc = 0, acc_cyc = 0;
    bit in_rsp = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .WAIT(WAIT_P)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );
    data_mem_responder #(.DEPTH(16), .WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0),
        .req_write(1'b1), .req_addr(16'h0000), .req_wdata(32'h0000_5A5A),
        .rsp_valid(rv0), .rsp_ready(1'b1), .rsp_rdata(rdata0),
        .rsp_err(err0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic bad(input logic [15:0] a);
`ifdef DMEM_ERR_EN
        return (a[1:0] != 2'b00) || (a[15:10] != 6'd0);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (req_ready && rsp_valid) check("ready_with_valid", 1, 0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
                else begin
                    if (!in_rsp) check("latency", 32'(cyc - acc_cyc - 1), WAIT_P + 1);
                    in_rsp = 1;
                    check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        in_rsp = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input exp_t e);
        bit ok = 0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 0; req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = $urandom;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    task automatic store(input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        e.rdata = '0; e.err = bad(a);
        if (!e.err) ref_mem[int'(a[9:2])] = d;
        issue(1'b1, a, d, e);
        drain();
    endtask

    task automatic load(input logic [15:0] a);
        exp_t e;
        e.err = bad(a);
        e.rdata = e.err ? 32'd0 : ref_mem[int'(a[9:2])];
        issue(1'b0, a, 32'hFFFF_FFFF, e);
        drain();
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 0;
        #1;
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"}, {31'd0, rsp_err}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        exp_q.delete();
        in_rsp = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 1);
    endtask

    initial begin
        exp_t e;
        int n_acc = 0, last = -1, overlap = 0;
        #12;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("idle_req_ready", {31'd0, req_ready}, 1);
        check("idle_rsp_rdata", rsp_rdata, 0);
        store(16'h0010, 32'hDEAD_BEEF);
        load(16'h0010);
        store(16'h0004, 32'h1234_5678);
        store(16'h0020, 32'h0BAD_F00D);
        store(16'h03FC, 32'hCAFE_BABE);
        store(16'h0000, 32'h55AA_55AA);
        load(16'h03FC);
        load(16'h0020);
        store(16'h0010, 32'h0000_0001);
        load(16'h0010);
        // backpressure: response must hold while rsp_ready is low
        @(posedge clk); #1;
        rsp_ready = 0;
        e.rdata = ref_mem[1]; e.err = 0;
        issue(1'b0, 16'h0004, 32'h0, e);
        wait_valid();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, rsp_valid}, 1);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        drain();
        @(negedge clk);
        check("bp_done_valid", {31'd0, rsp_valid}, 0);
        check("bp_done_ready", {31'd0, req_ready}, 1);
        // reset in WAIT aborts a pending store
        e.rdata = 0; e.err = 0;
        issue(1'b1, 16'h0020, 32'hA5A5_A5A5, e);
        @(negedge clk);
        check("wait_busy", {31'd0, busy}, 1);
        #1;
        pulse_reset("rst_wait");
        load(16'h0020);
        // reset while a response is held zeroes it immediately
        @(posedge clk); #1;
        rsp_ready = 0;
        e.rdata = ref_mem[4]; e.err = 0;
        issue(1'b0, 16'h0010, 32'h0, e);
        wait_valid();
        #1;
        rsp_ready = 1;
        pulse_reset("rst_resp");
        load(16'h0000);
`ifdef DMEM_ERR_EN
        store(16'h0402, 32'h7777_7777);
        load(16'h0400);
        load(16'h0013);
        load(16'h0000);
`else
        store(16'h0400, 32'h0000_0011);
        load(16'h0000);
        load(16'h0003);
`endif
        // WAIT=0 instance, request and response held ready: one accept every 3 cycles
        @(posedge clk); #1;
        v0 = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (v0 && rdy0) begin
                n_acc++;
                if (last >= 0) check("w0_spacing", 32'(i - last), 3);
                last = i;
            end
            if (rdy0 && rv0) overlap++;
            if (rv0) check("w0_rdata", rdata0, 0);
        end
        v0 = 0;
        check("w0_accepts", 32'(n_acc), 10);
        check("w0_overlap", 32'(overlap), 0);
        check("w0_err", {31'd0, err0}, 0);
        repeat (4) @(negedge clk);
        check("w0_idle", {31'd0, busy0}, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end
endmodule
